display_scanner: RTL and testbench
==================================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 6, giving the number of multiplexed 7-segment digits (range 2..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 1000, giving the clk cycles each digit is driven (range 2..65535).
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 32, giving the full frames per blink half-period (range 1..255).
REQ-004 The block SHALL have input clk, 1 bit, the clock; all state changes on its rising edge.
REQ-005 The block SHALL have input rst, 1 bit, the asynchronous, active-low reset.
REQ-006 The block SHALL have input en, 1 bit, the scan enable; when low, all internal counters hold.
REQ-007 The block SHALL have input digits, 4*NUM_DIGITS bits, BCD values from the clock counters, with digit k at bits [4k+3:4k] and digit 0 rightmost.
REQ-008 The block SHALL have input blink_mask, NUM_DIGITS bits, where a set bit marks that digit as blinking.
REQ-009 The block SHALL have output seg, 7 bits, active-high segments ordered {g,f,e,d,c,b,a}, registered.
REQ-010 The block SHALL have output an, NUM_DIGITS bits, active-low one-hot digit select, registered.
REQ-011 The block SHALL have output frame_done, 1 bit, a one-cycle pulse marking the end of each full scan frame.

Function
REQ-012 The prescaler p SHALL count 0..SCAN_DIV-1 on each clk with en=1 and wrap to 0.
REQ-013 Digit index i SHALL advance only on the cycle p wraps, counting 0..NUM_DIGITS-1 and wrapping to 0.
REQ-014 On the cycle p wraps with i==NUM_DIGITS-1, the block SHALL copy digits into a snapshot register and pulse frame_done for exactly that cycle.
REQ-015 The snapshot SHALL be used for all decoding, so a digits change mid-frame cannot tear the display.
REQ-016 The an and seg outputs SHALL update one clk after i changes, so each digit is driven for exactly SCAN_DIV cycles.
REQ-017 an SHALL be ~(1<<i) whenever the scanner is running.
REQ-018 seg SHALL decode the snapshot BCD value for digit i as: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
REQ-019 Any BCD value from 10 to 15 SHALL drive seg=00 (blank).
REQ-020 With en=0, p, i, the snapshot, an and seg SHALL all hold, and frame_done SHALL be 0.
REQ-021 The block SHALL handle these simultaneous events as follows:
- frame wrap and en fall in the same cycle: the wrap completes.
- en=0 on a wrap cycle: no wrap occurs.

Reset
REQ-022 While rst=0, the block SHALL force p=0, i=0, snapshot=0, blink phase=0, frame counter=0, an=all ones, seg=00 and frame_done=0.
REQ-023 After reset release, the first en=1 clk SHALL drive an=~1, with seg showing snapshot digit 0 (3F), until the first snapshot load.
REQ-024 A reset asserted mid-frame SHALL abort the frame with no frame_done pulse.

Configuration
REQ-025 The macro DISPLAY_BLINK_EN SHALL control the blink feature.
REQ-026 With DISPLAY_BLINK_EN defined:
- a frame counter SHALL toggle the blink phase every BLINK_FRAMES frame_done pulses;
- while phase=1 and blink_mask[i]=1, seg SHALL be 00, while an still scans normally.
REQ-027 With DISPLAY_BLINK_EN undefined:
- blink_mask SHALL remain a port but be ignored;
- the frame counter and phase logic SHALL be absent;
- the BLINK_FRAMES parameter SHALL be accepted and unused.

Verification
The bench SHALL use NUM_DIGITS=6, SCAN_DIV=4 and BLINK_FRAMES=2.
REQ-028 Hold rst=0, then release with en=1 and digits=0x123456 -> the following SHALL be observed:
- an=3F and seg=00 during reset;
- an=3E and seg=3F for the first 4 cycles;
- frame_done on cycle 24;
- the following frame shows digit 0 as seg=7D (6) through digit 5 as seg=06 (1).
REQ-029 Change digits from 0x123456 to 0x999999 while i=2 -> the current frame SHALL still show 1..6, the next frame SHALL show 9s, and no mixed frame SHALL occur.
REQ-030 Load digit 3 with 0xA..0xF -> seg SHALL be 00 while an=37.
REQ-031 Drop en for 10 cycles mid-digit -> an, seg and p SHALL be frozen, with no frame_done; on resume the remaining digit time SHALL equal 4 minus the cycles already spent.
REQ-032 Assert rst=0 at i=4, p=2 -> an=3F and seg=00 immediately, with no frame_done; after release, scanning SHALL restart at digit 0.
REQ-033 Define DISPLAY_BLINK_EN and set blink_mask=0x03 -> digits 0 and 1 SHALL show seg=00 in frames 3-4 and 7-8, and show normally in frames 1-2 and 5-6; without the macro, all frames SHALL show normally.

Source files
------------

// File: rtl/display_scanner.sv
// display_scanner: multiplexed 7-segment scanner for NUM_DIGITS BCD digits.
// Each digit is driven for SCAN_DIV clocks. The digits are snapshotted once per
// frame so that a display never shows a mix of two different values.
// Optional blink feature: define DISPLAY_BLINK_EN to blank the masked digits on
// alternating groups of BLINK_FRAMES frames.
module display_scanner #(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [PW-1:0]           p;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] snap;
    logic                    p_wrap;
    logic                    last_digit;
    logic [3:0]              cur_bcd;
    logic [NUM_DIGITS-1:0]   one_hot;
    logic [6:0]              seg_dec;
    logic                    blank;

    assign p_wrap     = (p == PW'(SCAN_DIV - 1));
    assign last_digit = (idx == IW'(NUM_DIGITS - 1));
    // The pulse is gated by en so that a stalled wrap cycle never reports a frame end.
    assign frame_done = rst & en & p_wrap & last_digit;

    // Prescaler, digit index and per-frame snapshot of the incoming digits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p    <= '0;
            idx  <= '0;
            snap <= '0;
        end else if (en) begin
            if (p_wrap) begin
                p <= '0;
                if (last_digit) begin
                    idx  <= '0;
                    snap <= digits;
                end else begin
                    idx <= idx + IW'(1);
                end
            end else begin
                p <= p + PW'(1);
            end
        end
    end

    // Select the snapshot nibble and anode position for the current digit.
    always_comb begin
        cur_bcd = 4'd0;
        one_hot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_bcd    = snap[4*k +: 4];
                one_hot[k] = 1'b1;
            end
        end
    end

    // BCD to segment decode; codes 10..15 blank the digit.
    always_comb begin
        seg_dec = 7'h00;
        case (cur_bcd)
            4'd0:    seg_dec = 7'h3F;
            4'd1:    seg_dec = 7'h06;
            4'd2:    seg_dec = 7'h5B;
            4'd3:    seg_dec = 7'h4F;
            4'd4:    seg_dec = 7'h66;
            4'd5:    seg_dec = 7'h6D;
            4'd6:    seg_dec = 7'h7D;
            4'd7:    seg_dec = 7'h07;
            4'd8:    seg_dec = 7'h7F;
            4'd9:    seg_dec = 7'h6F;
            default: seg_dec = 7'h00;
        endcase
    end

`ifdef DISPLAY_BLINK_EN
    logic [7:0] frame_cnt;
    logic       phase;
    logic       cur_mask;

    // Pick the blink mask bit of the digit being scanned.
    always_comb begin
        cur_mask = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_mask = blink_mask[k];
            end
        end
    end

    // Count completed frames and flip the blink phase every BLINK_FRAMES of them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= 8'd0;
            phase     <= 1'b0;
        end else if (frame_done) begin
            if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                frame_cnt <= 8'd0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign blank = phase & cur_mask;
`else
    logic unused_blink;

    assign unused_blink = ^{blink_mask, 8'(BLINK_FRAMES)};
    assign blank        = 1'b0;
`endif

    // Registered outputs follow the digit index one clock later and hold with en low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= '1;
            seg <= 7'h00;
        end else if (en) begin
            an  <= ~one_hot;
            seg <= blank ? 7'h00 : seg_dec;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: directed self-checking bench for display_scanner with
// NUM_DIGITS=6, SCAN_DIV=4, BLINK_FRAMES=2. Expected segment codes come from
// a hand-typed BCD table; blink expectations follow DISPLAY_BLINK_EN.
module tb_display_scanner;

    logic        clk;
    logic        rst;
    logic        en;
    logic [23:0] digits;
    logic [5:0]  blink_mask;
    logic [6:0]  seg;
    logic [5:0]  an;
    logic        frame_done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

`ifdef DISPLAY_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    display_scanner #(
        .NUM_DIGITS  (6),
        .SCAN_DIV    (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .digits    (digits),
        .blink_mask(blink_mask),
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] bcd7(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic en_v, input logic [23:0] dig_v, input logic [5:0] mask_v);
        en         = en_v;
        digits     = dig_v;
        blink_mask = mask_v;
    endtask

    task automatic checkOutput(input string tag, input logic [5:0] exp_an, input logic [6:0] exp_seg,
                               input logic exp_fd);
        n_checks++;
        assert (an === exp_an) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s an actual=%h required=%h", tag, an, exp_an);
        end
        n_checks++;
        assert (seg === exp_seg) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s seg actual=%h required=%h", tag, seg, exp_seg);
        end
        n_checks++;
        assert (frame_done === exp_fd) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s frame_done actual=%b required=%b", tag, frame_done, exp_fd);
        end
    endtask

    // One full frame of 6 digits x 4 cycles; optional mid-frame digit change,
    // en stall of 10 cycles, or reset abort at digit abort_d (internal p=2).
    task automatic runFrame(input string tag, input logic [23:0] shown, input logic [5:0] blank,
                            input int chg_d, input logic [23:0] new_dig,
                            input int pause_d, input int pause_k, input int abort_d);
        logic [5:0] exp_an;
        logic [6:0] exp_seg;
        for (int d = 0; d < 6; d++) begin
            for (int k = 0; k < 4; k++) begin
                step();
                exp_an  = ~(6'd1 << d);
                exp_seg = blank[d] ? 7'h00 : bcd7(shown[4*d +: 4]);
                checkOutput(tag, exp_an, exp_seg, (d == 5 && k == 2));
                if (d == chg_d && k == 0) begin
                    applyStimulus(1'b1, new_dig, blink_mask);
                end
                if (d == pause_d && k == pause_k) begin
                    applyStimulus(1'b0, digits, blink_mask);
                    repeat (10) begin
                        step();
                        checkOutput({tag, "_hold"}, exp_an, exp_seg, 1'b0);
                    end
                    applyStimulus(1'b1, digits, blink_mask);
                end
                if (d == abort_d && k == 1) begin
                    rst = 1'b0;
                    #1;
                    checkOutput({tag, "_abort"}, 6'h3F, 7'h00, 1'b0);
                    repeat (3) begin
                        step();
                        checkOutput({tag, "_inrst"}, 6'h3F, 7'h00, 1'b0);
                    end
                    return;
                end
            end
        end
    endtask

    initial begin
        logic [23:0] dv;
        logic [23:0] nv;
        logic [5:0]  bl;

        rst = 1'b0;
        applyStimulus(1'b1, 24'h123456, 6'h00);

        repeat (3) begin
            step();
            checkOutput("reset", 6'h3F, 7'h00, 1'b0);
        end
        rst = 1'b1;

        // Frame 1 shows the cleared snapshot, frame 2 the loaded digits.
        runFrame("frame1", 24'h000000, 6'h00, -1, 24'h0, -1, 0, -1);
        runFrame("frame2", 24'h123456, 6'h00, -1, 24'h0, -1, 0, -1);

        // Digits change while digit 2 is scanned: no tearing.
        runFrame("tear_cur", 24'h123456, 6'h00, 2, 24'h999999, -1, 0, -1);
        runFrame("tear_next", 24'h999999, 6'h00, 0, 24'h12A456, -1, 0, -1);

        // Invalid BCD codes on digit 3 blank it.
        for (int v = 10; v < 16; v++) begin
            dv = 24'h120456 | (24'(v) << 12);
            nv = (v == 15) ? 24'h123456 : (24'h120456 | (24'(v + 1) << 12));
            runFrame("bad_bcd", dv, 6'h00, 0, nv, -1, 0, -1);
        end

        // en stall mid-digit and on the frame wrap cycle.
        runFrame("stall_mid", 24'h123456, 6'h00, -1, 24'h0, 1, 1, -1);
        runFrame("stall_wrap", 24'h123456, 6'h00, -1, 24'h0, 5, 2, -1);

        // Reset mid-frame at digit 4, then restart with the blink mask set.
        runFrame("abort", 24'h123456, 6'h00, -1, 24'h0, -1, 0, 4);
        applyStimulus(1'b1, 24'h123456, 6'h03);
        rst = 1'b1;

        for (int f = 1; f <= 8; f++) begin
            dv = (f == 1) ? 24'h000000 : 24'h123456;
            bl = (BLINK_ON && (f == 3 || f == 4 || f == 7 || f == 8)) ? 6'h03 : 6'h00;
            runFrame("blink", dv, bl, -1, 24'h0, -1, 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
